// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA timing / tile-fetch block:
//   - 640x480@60 timing constants used as parameter defaults
//   - sync_pol_t: asserted level of the hsync/vsync outputs
//   - idx_w():    index width for a count of n items (never below 1 bit)
//   - sync_level(): maps "inside sync window" to the pin level for a polarity
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } sync_pol_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic sync_level(input logic in_window, input sync_pol_t pol);
        return in_window ? logic'(pol) : ~logic'(pol);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
//   One axis (horizontal or vertical) of a raster position counter with an
//   incremental block decomposition (pos = blk*BLK + sub inside the active
//   region). Advances once per step_i; wraps at TOTAL-1.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (state -> RST_VAL)
//     step_i       advance by one position
//     pos_q_o      current position (registered)
//     pos_d_o      position after this cycle's step
//     act_d_o      pos_d_o < ACTIVE
//     sub_d_o      position inside the block after this step
//     blk_d_o      block index after this step
//     wrap_o       this step wraps the position back to 0
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL   = 800,
    parameter int unsigned ACTIVE  = 640,
    parameter int unsigned BLK     = 20,
    parameter int unsigned RST_VAL = 640,
    localparam int unsigned PW = idx_w(TOTAL),
    localparam int unsigned NB = ACTIVE / BLK,
    localparam int unsigned BW = idx_w(NB),
    localparam int unsigned SW = idx_w(BLK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_i,
    output logic [PW-1:0] pos_q_o,
    output logic [PW-1:0] pos_d_o,
    output logic          act_d_o,
    output logic [SW-1:0] sub_d_o,
    output logic [BW-1:0] blk_d_o,
    output logic          wrap_o
);

    // In blanking the block counters park on the last block of the line, so
    // a reset value in blanking uses that parked state.
    localparam int unsigned SUB_RST = (RST_VAL < ACTIVE) ? (RST_VAL % BLK) : (BLK - 1);
    localparam int unsigned BLK_RST = (RST_VAL < ACTIVE) ? (RST_VAL / BLK) : (NB - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          wrap;

    always_comb begin
        pos_d = pos_q;
        sub_d = sub_q;
        blk_d = blk_q;
        wrap  = 1'b0;
        if (step_i) begin
            if (pos_q == PW'(TOTAL - 1)) begin
                wrap  = 1'b1;
                pos_d = '0;
                sub_d = '0;
                blk_d = '0;
            end else begin
                pos_d = pos_q + PW'(1);
                // Block counters only move while the next position is still
                // active; they never run past the last block.
                if (pos_q < PW'(ACTIVE - 1)) begin
                    if (sub_q == SW'(BLK - 1)) begin
                        sub_d = '0;
                        blk_d = blk_q + BW'(1);
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= PW'(RST_VAL);
            sub_q <= SW'(SUB_RST);
            blk_q <= BW'(BLK_RST);
        end else begin
            pos_q <= pos_d;
            sub_q <= sub_d;
            blk_q <= blk_d;
        end
    end

    assign pos_q_o = pos_q;
    assign pos_d_o = pos_d;
    assign act_d_o = (pos_d < PW'(ACTIVE));
    assign sub_d_o = sub_d;
    assign blk_d_o = blk_d;
    assign wrap_o  = wrap;

endmodule

// File: rtl/vga_block_timing.sv
// ----------------------------------------------------------------------------
// vga_block_timing
//   VGA raster timing plus block-aligned tile-RAM read generation. A display
//   counter pair produces the visible position and syncs; a fetch counter
//   pair runs RD_LAT en-cycles ahead and issues one read per active block so
//   tile data is ready when pix_load marks the block's first pixel.
//   Ports:
//     clk          clock
//     reset        asynchronous active-low reset
//     en           pixel enable; all state advances only when en=1
//     x, y         displayed column / line
//     active       x < H_ACTIVE && y < V_ACTIVE
//     hsync, vsync sync outputs, asserted level SYNC_POL
//     line_start   one-cycle pulse when x==0
//     frame_start  one-cycle pulse when x==0 && y==0
//     re           one-cycle tile read strobe
//     raddr        {by, bx} of the block being fetched (held in blanking)
//     pix_load     one-cycle pulse on the first pixel of each active block
// ----------------------------------------------------------------------------
module vga_block_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned BLK_W    = 20,
    parameter int unsigned BLK_H    = 20,
    parameter int unsigned RD_LAT   = 2,
    parameter sync_pol_t   SYNC_POL = ACTIVE_LOW,
    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned GW    = H_ACTIVE / BLK_W,
    localparam int unsigned GH    = V_ACTIVE / BLK_H,
    localparam int unsigned XW    = idx_w(H_TOT),
    localparam int unsigned YW    = idx_w(V_TOT),
    localparam int unsigned BXW   = idx_w(GW),
    localparam int unsigned BYW   = idx_w(GH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic               re,
    output logic [BYW+BXW-1:0] raddr,
    output logic               pix_load
);

    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned RD_MAX  = ((BLK_W - 1) < H_BLANK) ? (BLK_W - 1) : H_BLANK;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = HS_LO + H_SYNC - 1;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = VS_LO + V_SYNC - 1;
    localparam int unsigned SWH     = idx_w(BLK_W);
    localparam int unsigned SWV     = idx_w(BLK_H);

    // Fetch reset = display reset position (H_ACTIVE, V_TOT-1) + RD_LAT; the
    // lead may carry exactly into (0,0) when RD_LAT spans the whole hblank.
    localparam int unsigned F_X_LIN = H_ACTIVE + RD_LAT;
    localparam int unsigned F_X_RST = (F_X_LIN >= H_TOT) ? (F_X_LIN - H_TOT) : F_X_LIN;
    localparam int unsigned F_Y_RST = (F_X_LIN >= H_TOT) ? 0 : (V_TOT - 1);

    localparam logic SYNC_IDLE = sync_level(1'b0, SYNC_POL);

    if ((H_ACTIVE % BLK_W) != 0) begin : g_bad_blk_w
        $error("vga_block_timing: BLK_W must divide H_ACTIVE");
    end
    if ((V_ACTIVE % BLK_H) != 0) begin : g_bad_blk_h
        $error("vga_block_timing: BLK_H must divide V_ACTIVE");
    end
    if ((RD_LAT < 1) || (RD_LAT > RD_MAX)) begin : g_bad_rd_lat
        $error("vga_block_timing: RD_LAT out of range");
    end

    logic [XW-1:0]  dh_pos_q, dh_pos_d, fh_pos_q, fh_pos_d;
    logic [YW-1:0]  dv_pos_q, dv_pos_d, fv_pos_q, fv_pos_d;
    logic           dh_act_d, dv_act_d, fh_act_d, fv_act_d;
    logic [SWH-1:0] dh_sub_d, fh_sub_d;
    logic [SWV-1:0] dv_sub_d, fv_sub_d;
    logic [BXW-1:0] dh_blk_d, fh_blk_d;
    logic [BYW-1:0] dv_blk_d, fv_blk_d;
    logic           dh_wrap, dv_wrap, fh_wrap, fv_wrap;

    vga_axis_counter #(.TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .BLK(BLK_W), .RST_VAL(H_ACTIVE)) u_disp_h (
        .clk(clk), .rst_n(reset), .step_i(en),
        .pos_q_o(dh_pos_q), .pos_d_o(dh_pos_d), .act_d_o(dh_act_d),
        .sub_d_o(dh_sub_d), .blk_d_o(dh_blk_d), .wrap_o(dh_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .BLK(BLK_H), .RST_VAL(V_TOT - 1)) u_disp_v (
        .clk(clk), .rst_n(reset), .step_i(dh_wrap),
        .pos_q_o(dv_pos_q), .pos_d_o(dv_pos_d), .act_d_o(dv_act_d),
        .sub_d_o(dv_sub_d), .blk_d_o(dv_blk_d), .wrap_o(dv_wrap)
    );

    vga_axis_counter #(.TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .BLK(BLK_W), .RST_VAL(F_X_RST)) u_fetch_h (
        .clk(clk), .rst_n(reset), .step_i(en),
        .pos_q_o(fh_pos_q), .pos_d_o(fh_pos_d), .act_d_o(fh_act_d),
        .sub_d_o(fh_sub_d), .blk_d_o(fh_blk_d), .wrap_o(fh_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .BLK(BLK_H), .RST_VAL(F_Y_RST)) u_fetch_v (
        .clk(clk), .rst_n(reset), .step_i(fh_wrap),
        .pos_q_o(fv_pos_q), .pos_d_o(fv_pos_d), .act_d_o(fv_act_d),
        .sub_d_o(fv_sub_d), .blk_d_o(fv_blk_d), .wrap_o(fv_wrap)
    );

    // Counter outputs this top level has no use for.
    logic unused_ok;
    assign unused_ok = ^{dh_blk_d, dv_sub_d, dv_blk_d, dv_wrap,
                         fh_pos_q, fh_pos_d, fv_pos_q, fv_pos_d, fv_sub_d, fv_wrap};

    logic               active_q, active_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               re_q, re_d;
    logic               pix_load_q, pix_load_d;
    logic [BYW+BXW-1:0] raddr_q, raddr_d;

    // Output registers are loaded from the counters' next values so they line
    // up with x/y, which are the counter registers themselves.
    always_comb begin
        active_d      = dh_act_d && dv_act_d;
        hsync_d       = sync_level((dh_pos_d >= XW'(HS_LO)) && (dh_pos_d <= XW'(HS_HI)), SYNC_POL);
        vsync_d       = sync_level((dv_pos_d >= YW'(VS_LO)) && (dv_pos_d <= YW'(VS_HI)), SYNC_POL);
        line_start_d  = en && (dh_pos_d == '0);
        frame_start_d = line_start_d && (dv_pos_d == '0);
        pix_load_d    = en && active_d && (dh_sub_d == '0);
        re_d          = en && fh_act_d && fv_act_d && (fh_sub_d == '0);
        raddr_d       = re_d ? {fv_blk_d, fh_blk_d} : raddr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q      <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            re_q          <= 1'b0;
            pix_load_q    <= 1'b0;
            raddr_q       <= '0;
        end else begin
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            re_q          <= re_d;
            pix_load_q    <= pix_load_d;
            raddr_q       <= raddr_d;
        end
    end

    assign x           = dh_pos_q;
    assign y           = dv_pos_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign re          = re_q;
    assign raddr       = raddr_q;
    assign pix_load    = pix_load_q;

endmodule
